// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// mode_t : pattern selection as seen on the mode input pins.
// dir_t  : travel direction used by the ping-pong pattern.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ROT_UP    = 2'd0,
        ROT_DOWN  = 2'd1,
        PING_PONG = 2'd2,
        FILL      = 2'd3
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/led_sequencer_tick_prescaler.sv
// Free-running divider producing one tick every PRESCALE enabled cycles.
// Latency: tick is a combinational decode of the counter (same cycle as pc==PRESCALE-1).
// Backpressure: none; en=0 parks the counter at 0, clr restarts the period.
//
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   clr    : synchronous restart of the period (pc <= 0)
//   en     : count enable; while low the counter is held at 0
//   tick   : high for the cycle in which pc sits on its last value and en=1
module tick_prescaler #(
    parameter int unsigned PRESCALE = 100_000_000
) (
    input  logic clk,
    input  logic resetN,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // PRESCALE=1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pc;
    logic          w_at_last;

    assign w_at_last = (r_pc == PC_LAST);
    assign tick      = en && w_at_last;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pc <= '0;
        end else if (clr || !en) begin
            // Holding at 0 while disabled makes a resume wait a full period.
            r_pc <= '0;
        end else if (w_at_last) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + 1'b1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate up/down, ping-pong and bar-fill over NUM_LEDS outputs.
// Latency: leds/pos change the cycle after an advance is registered; tick marks that cycle.
// Backpressure: none; pause freezes the pattern, step rising edge advances once while paused.
//
// Ports:
//   clk    : system clock, single domain
//   resetN : asynchronous active-low reset
//   mode   : pattern select (mode_t encoding), synchronous to clk
//   pause  : level, 1 freezes the pattern
//   step   : single-step request, rising edge honoured only while pause=1
//   leds   : LED drive (decode of position and registered mode)
//   pos    : current position / fill level
//   tick   : one-cycle pulse coinciding with each new position
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter  int unsigned NUM_LEDS = 4,
    parameter  int unsigned PRESCALE = 100_000_000,
    localparam int unsigned CW       = $clog2(NUM_LEDS + 1)
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [1:0]          mode,
    input  logic                pause,
    input  logic                step,
    output logic [NUM_LEDS-1:0] leds,
    output logic [CW-1:0]       pos,
    output logic                tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_LEDS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Registered pattern state
    logic [CW-1:0] r_cnt;
    dir_t          r_dir;
    mode_t         r_mode;
    logic          r_step_q;
    logic          r_tick;

    // Combinational helpers
    mode_t              w_mode;
    logic               w_mode_chg;
    logic               w_adv_pc;
    logic               w_adv_step;
    logic               w_adv;
    logic [CW-1:0]      w_cnt_nxt;
    dir_t               w_dir_nxt;
    logic [NUM_LEDS-1:0] w_leds;

    assign w_mode     = mode_t'(mode);
    assign w_mode_chg = (w_mode != r_mode);
    assign w_adv_step = pause && step && !r_step_q;
    assign w_adv      = w_adv_pc || w_adv_step;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .resetN (resetN),
        .clr    (w_mode_chg),
        .en     (!pause),
        .tick   (w_adv_pc)
    );

    // Position that follows r_cnt for the active pattern. Out-of-range
    // values fold back to a legal position rather than running away.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        case (r_mode)
            ROT_UP: begin
                w_cnt_nxt = (r_cnt >= CNT_LAST) ? '0 : r_cnt + CNT_ONE;
            end
            ROT_DOWN: begin
                w_cnt_nxt = (r_cnt == '0 || r_cnt > CNT_LAST) ? CNT_LAST : r_cnt - CNT_ONE;
            end
            PING_PONG: begin
                // dir flips on arrival at an end, so each end LED shows for one step.
                if (r_dir == UP) begin
                    if (r_cnt >= CNT_LAST - CNT_ONE) begin
                        w_cnt_nxt = CNT_LAST;
                        w_dir_nxt = DOWN;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else begin
                    if (r_cnt <= CNT_ONE || r_cnt > CNT_LAST) begin
                        w_cnt_nxt = '0;
                        w_dir_nxt = UP;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
            end
            FILL: begin
                w_cnt_nxt = (r_cnt >= CNT_FULL) ? '0 : r_cnt + CNT_ONE;
            end
            default: begin
                w_cnt_nxt = '0;
                w_dir_nxt = UP;
            end
        endcase
    end

    // Pattern state machine. A mode change restarts the pattern and
    // swallows any advance landing in the same cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt    <= '0;
            r_dir    <= UP;
            r_mode   <= ROT_UP;
            r_step_q <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_step_q <= step;
            if (w_mode_chg) begin
                r_mode <= w_mode;
                r_cnt  <= '0;
                r_dir  <= UP;
                r_tick <= 1'b0;
            end else begin
                r_tick <= w_adv;
                if (w_adv) begin
                    r_cnt <= w_cnt_nxt;
                    r_dir <= w_dir_nxt;
                end
            end
        end
    end

    // FILL lights every LED below the level; the other patterns light one.
    always_comb begin
        w_leds = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (r_mode == FILL) begin
                w_leds[i] = (CW'(i) < r_cnt);
            end else begin
                w_leds[i] = (CW'(i) == r_cnt);
            end
        end
    end

    assign leds = w_leds;
    assign pos  = r_cnt;
    assign tick = r_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with NUM_LEDS=4, PRESCALE=4.
// A pattern-index model (advances counted since the last restart) is compared
// every cycle, and directed literal sequences pin the model itself.
module tb_led_sequencer;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk    = 1'b0;
    logic          resetN = 1'b1;
    logic [1:0]    mode   = 2'd0;
    logic          pause  = 1'b0;
    logic          step   = 1'b0;
    logic [N-1:0]  leds;
    logic [CW-1:0] pos;
    logic          tick;

    int errors = 0;
    int checks = 0;

    led_sequencer #(
        .NUM_LEDS (N),
        .PRESCALE (P)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .mode   (mode),
        .pause  (pause),
        .step   (step),
        .leds   (leds),
        .pos    (pos),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern position as a function of advances k since the pattern restarted.
    function automatic int exp_pos(input int md, input int k);
        int m;
        case (md)
            0: return k % N;
            1: return (N - (k % N)) % N;
            2: begin
                m = k % (2 * N - 2);
                return (m < N) ? m : (2 * N - 2 - m);
            end
            default: return k % (N + 1);
        endcase
    endfunction

    function automatic logic [N-1:0] exp_leds(input int md, input int k);
        int p;
        p = exp_pos(md, k);
        if (md == 3) return N'((1 << p) - 1);
        return N'(1 << p);
    endfunction

    // Behavioural model: mode, advance count, enabled-cycle phase, step history.
    int m_mode  = 0;
    int m_k     = 0;
    int m_phase = 0;
    bit m_step_prev = 1'b0;
    bit m_tick  = 1'b0;
    bit m_adv;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_mode = 0; m_k = 0; m_phase = 0; m_step_prev = 1'b0; m_tick = 1'b0;
        end else begin
            m_adv = (!pause && m_phase == P - 1) || (pause && step && !m_step_prev);
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode); m_k = 0; m_phase = 0; m_tick = 1'b0;
            end else begin
                m_tick = m_adv;
                if (m_adv) m_k++;
                m_phase = pause ? 0 : (m_phase + 1) % P;
            end
            m_step_prev = step;
        end
    end

    always @(negedge clk) begin
        check("model_leds", 32'(leds), 32'(exp_leds(m_mode, m_k)));
        check("model_pos",  32'(pos),  32'(exp_pos(m_mode, m_k)));
        check("model_tick", 32'(tick), 32'(m_tick));
    end

    logic [N-1:0] rotup_tab[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] pp_tab[8]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [N-1:0] fill_tab[6]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    logic [N-1:0] rd_tab[4]    = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};

    task automatic lit(input string nm, input logic [N-1:0] el, input logic et);
        check({nm, "_leds"}, 32'(leds), 32'(el));
        check({nm, "_tick"}, 32'(tick), 32'(et));
    endtask

    initial begin
        int tick_cnt;

        #1 resetN = 1'b0;
        @(negedge clk);
        check("rst_leds", 32'(leds), 32'(4'b0001));
        check("rst_pos",  32'(pos),  32'(0));
        @(negedge clk);
        #2 resetN = 1'b1;

        // ROT_UP after release
        repeat (3) @(negedge clk);
        lit("rotup_hold", 4'b0001, 1'b0);
        @(negedge clk);
        lit("rotup0", rotup_tab[0], 1'b1);
        for (int i = 1; i < 4; i++) begin
            repeat (P) @(negedge clk);
            lit("rotup", rotup_tab[i], 1'b1);
        end

        // PING_PONG
        mode = 2'd2;
        @(negedge clk);
        lit("pp_start", pp_tab[0], 1'b0);
        for (int i = 1; i < 8; i++) begin
            repeat (P) @(negedge clk);
            lit("pp", pp_tab[i], 1'b1);
        end

        // FILL
        mode = 2'd3;
        @(negedge clk);
        lit("fill_start", fill_tab[0], 1'b0);
        for (int i = 1; i < 6; i++) begin
            repeat (P) @(negedge clk);
            lit("fill", fill_tab[i], 1'b1);
        end

        // ROT_DOWN
        mode = 2'd1;
        @(negedge clk);
        lit("rd_start", rd_tab[0], 1'b0);
        for (int i = 1; i < 4; i++) begin
            repeat (P) @(negedge clk);
            lit("rd", rd_tab[i], 1'b1);
        end

        // Pause for 20 cycles: frozen at 0010, no ticks
        pause = 1'b1;
        tick_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            check("pause_leds", 32'(leds), 32'(4'b0010));
            tick_cnt += int'(tick);
        end
        check("pause_ticks", 32'(tick_cnt), 32'(0));

        // Step held high for 5 cycles: one advance
        step = 1'b1;
        tick_cnt = 0;
        @(negedge clk);
        lit("step_adv", 4'b0001, 1'b1);
        tick_cnt += int'(tick);
        repeat (4) begin
            @(negedge clk);
            tick_cnt += int'(tick);
        end
        step = 1'b0;
        check("step_leds", 32'(leds), 32'(4'b0001));
        check("step_ticks", 32'(tick_cnt), 32'(1));

        // Resume, with step pulses that must be ignored
        pause = 1'b0;
        step  = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        lit("run_step_ign", 4'b0001, 1'b0);
        @(negedge clk);
        lit("resume_adv", 4'b1000, 1'b1);

        // Mode change colliding with an advance
        mode = 2'd0;
        repeat (4) @(negedge clk);
        mode = 2'd3;
        @(negedge clk);
        lit("coll", 4'b0000, 1'b0);
        check("coll_pos", 32'(pos), 32'(0));
        repeat (3) @(negedge clk);
        lit("coll_hold", 4'b0000, 1'b0);
        @(negedge clk);
        lit("coll_next", 4'b0001, 1'b1);

        // Asynchronous reset mid-pattern
        mode = 2'd0;
        @(negedge clk);
        repeat (2 * P) @(negedge clk);
        check("pre_areset_leds", 32'(leds), 32'(4'b0100));
        #2 resetN = 1'b0;
        #1;
        check("areset_leds", 32'(leds), 32'(4'b0001));
        check("areset_pos",  32'(pos),  32'(0));
        @(negedge clk);
        #2 resetN = 1'b1;

        // Randomised run against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if (!resetN) begin
                #2 resetN = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                #2 resetN = 1'b0;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
